// File: rtl/apb_irq_test_slv_pkg.sv
// Shared definitions for the APB interrupt test slave: register map, CTRL layout,
// wait-counter width and the bus FSM state type.
package apb_test_pkg;

  localparam logic [7:0] OFS_ID     = 8'h00;
  localparam logic [7:0] OFS_CTRL   = 8'h04;
  localparam logic [7:0] OFS_STATUS = 8'h08;
  localparam logic [7:0] OFS_SWSET  = 8'h0C;
  localparam logic [7:0] OFS_LOAD   = 8'h10;
  localparam logic [7:0] OFS_CNT    = 8'h14;
  localparam logic [7:0] OFS_CH     = 8'h18;
  localparam logic [7:0] OFS_SCR    = 8'h20;

  localparam int WAIT_W = 4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_RL       = 1;
  localparam int CTRL_MASK_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } apb_st_e;

endpackage

// File: rtl/apb_irq_test_slv_if.sv
// APB3 bus bundle between a master and the interrupt test slave.
interface apb_irq_test_slv_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_irq_test_slv_tmr.sv
// Countdown timer: reload register, decrement, auto-reload and a one-hot pending-set
// pulse on the selected channel when the count steps from 1 to 0.
module apb_irq_tmr #(
  parameter int DATA_W  = 32,
  parameter int IRQ_NUM = 8,
  parameter int CH_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               auto_reload,
  input  logic               load_we,
  input  logic [DATA_W-1:0]  load_val,
  input  logic [CH_W-1:0]    ch,
  output logic [DATA_W-1:0]  load,
  output logic [DATA_W-1:0]  cnt,
  output logic [IRQ_NUM-1:0] set
);

  logic fire;

  // A register write in the same cycle suppresses the decrement, hence no expiry.
  assign fire = en & ~load_we & (cnt == DATA_W'(1));

  always_comb begin
    set = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (fire && ch == CH_W'(i)) set[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load <= '0;
      cnt  <= '0;
    end else if (load_we) begin
      load <= load_val;
      cnt  <= load_val;
    end else if (en) begin
      if (cnt != '0)       cnt <= cnt - DATA_W'(1);
      else if (auto_reload) cnt <= load;
    end
  end

endmodule

// File: rtl/apb_irq_test_slv.sv
// APB3 test slave: register file, programmable wait states, error decode and a
// timer/software driven level interrupt source.
module apb_irq_test_slv
  import apb_test_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NUM_SCR  = 4,
  parameter int                WAIT_CYC = 0,
  parameter int                IRQ_NUM  = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h4D56_5531
) (
  input  logic               clk,
  input  logic               rst_n,
  apb_irq_test_slv_if.slave  apb,
  output logic [IRQ_NUM-1:0] irq
);

  localparam int CH_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  apb_st_e             state, state_nxt;
  logic [WAIT_W-1:0]   wcnt, wcnt_nxt;
  logic                access, ready, fin;
  logic [7:0]          off;
  logic                hit, err, we;
  logic [DATA_W-1:0]   rd_val;
  logic                tmr_en, tmr_rl;
  logic [IRQ_NUM-1:0]  mask, pending, tmr_set, sw_set, w1c;
  logic [CH_W-1:0]     tmr_ch;
  logic [DATA_W-1:0]   tmr_load, tmr_cnt;
  logic [DATA_W-1:0]   scr [NUM_SCR];
  logic                unused_paddr;

  assign access       = apb.psel & apb.penable;
  assign off          = apb.paddr[7:0];
  assign unused_paddr = ^apb.paddr[ADDR_W-1:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // The first access cycle counts as the first wait state; DONE is the single ready cycle.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    ready     = 1'b1;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (WAIT_CYC == 0) begin
            fin = 1'b1;
          end else begin
            ready     = 1'b0;
            wcnt_nxt  = WAIT_W'(1);
            state_nxt = (WAIT_CYC == 1) ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!access) begin
          state_nxt = ST_IDLE;
          wcnt_nxt  = '0;
        end else begin
          ready = 1'b0;
          if (wcnt == WAIT_LAST) begin
            state_nxt = ST_DONE;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + WAIT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        wcnt_nxt  = '0;
        fin       = access;
      end
      default: begin
        state_nxt = ST_IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    hit    = 1'b0;
    rd_val = '0;
    case (off)
      OFS_ID:     begin hit = 1'b1; rd_val = ID_VALUE; end
      OFS_CTRL: begin
        hit                              = 1'b1;
        rd_val[CTRL_EN]                  = tmr_en;
        rd_val[CTRL_RL]                  = tmr_rl;
        rd_val[CTRL_MASK_LSB +: IRQ_NUM] = mask;
      end
      OFS_STATUS: begin hit = 1'b1; rd_val[IRQ_NUM-1:0] = pending; end
      OFS_SWSET:  hit = 1'b1;
      OFS_LOAD:   begin hit = 1'b1; rd_val = tmr_load; end
      OFS_CNT:    begin hit = 1'b1; rd_val = tmr_cnt; end
      OFS_CH:     begin hit = 1'b1; rd_val[CH_W-1:0] = tmr_ch; end
      default: ;
    endcase
    for (int k = 0; k < NUM_SCR; k++) begin
      if (off == OFS_SCR + 8'(4 * k)) begin
        hit    = 1'b1;
        rd_val = scr[k];
      end
    end
  end

  assign err = (apb.paddr[1:0] != 2'b00) | ~hit |
               (apb.pwrite & ((off == OFS_ID) | (off == OFS_CNT)));
  assign we  = fin & apb.pwrite & ~err;

  assign apb.pready  = ready;
  assign apb.pslverr = fin & err;
  assign apb.prdata  = (fin && !err && !apb.pwrite) ? rd_val : '0;

  assign sw_set = (we && off == OFS_SWSET)  ? apb.pwdata[IRQ_NUM-1:0] : '0;
  assign w1c    = (we && off == OFS_STATUS) ? apb.pwdata[IRQ_NUM-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_en  <= 1'b0;
      tmr_rl  <= 1'b0;
      mask    <= '0;
      tmr_ch  <= '0;
      pending <= '0;
      irq     <= '0;
      for (int k = 0; k < NUM_SCR; k++) scr[k] <= '0;
    end else begin
      if (we && off == OFS_CTRL) begin
        tmr_en <= apb.pwdata[CTRL_EN];
        tmr_rl <= apb.pwdata[CTRL_RL];
        mask   <= apb.pwdata[CTRL_MASK_LSB +: IRQ_NUM];
      end
      if (we && off == OFS_CH) tmr_ch <= apb.pwdata[CH_W-1:0];
      // Sets are ORed in after the clear so a coincident set always survives.
      pending <= (pending & ~w1c) | sw_set | tmr_set;
      irq     <= pending & mask;
      for (int k = 0; k < NUM_SCR; k++) begin
        if (we && off == OFS_SCR + 8'(4 * k)) scr[k] <= apb.pwdata;
      end
    end
  end

  apb_irq_tmr #(
    .DATA_W  (DATA_W),
    .IRQ_NUM (IRQ_NUM),
    .CH_W    (CH_W)
  ) u_tmr (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (tmr_en),
    .auto_reload (tmr_rl),
    .load_we     (we && off == OFS_LOAD),
    .load_val    (apb.pwdata),
    .ch          (tmr_ch),
    .load        (tmr_load),
    .cnt         (tmr_cnt),
    .set         (tmr_set)
  );

endmodule

// File: tb/tb_apb_irq_test_slv.sv
// Bench for apb_irq_test_slv: directed map/error/timer/reset checks plus randomized
// register traffic against a behavioural register-map model.
module tb_apb_irq_test_slv;

  localparam int WAIT_CYC = 3;
  localparam int IRQ_NUM  = 8;
  localparam int NUM_SCR  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_irq_test_slv_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  logic [IRQ_NUM-1:0] irq;

  apb_irq_test_slv #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NUM_SCR  (NUM_SCR),
    .WAIT_CYC (WAIT_CYC),
    .IRQ_NUM  (IRQ_NUM),
    .ID_VALUE (32'h4D56_5531)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .apb   (bus),
    .irq   (irq)
  );

  int n_chk = 0;
  int n_err = 0;
  int last_ce = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register-map model
  logic [31:0] m_scr [NUM_SCR];
  logic        m_en, m_rl;
  logic [7:0]  m_mask, m_pend;
  logic [31:0] m_load, m_cnt;
  logic [2:0]  m_ch;

  task automatic model_reset();
    m_en = 0; m_rl = 0; m_mask = 0; m_pend = 0; m_load = 0; m_cnt = 0; m_ch = 0;
    for (int k = 0; k < NUM_SCR; k++) m_scr[k] = 0;
  endtask

  function automatic logic m_err(input logic wr, input logic [31:0] a);
    int o;
    o = int'(a[7:0]);
    if (a[1:0] != 2'b00) return 1'b1;
    if (wr && (o == 'h00 || o == 'h14)) return 1'b1;
    if (o <= 'h18) return 1'b0;
    if (o >= 'h20 && o < 'h20 + 4 * NUM_SCR) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int o;
    o = int'(a[7:0]);
    case (o)
      'h00:    return 32'h4D56_5531;
      'h04:    return {16'h0, m_mask, 6'h0, m_rl, m_en};
      'h08:    return {24'h0, m_pend};
      'h0C:    return 32'h0;
      'h10:    return m_load;
      'h14:    return m_cnt;
      'h18:    return {29'h0, m_ch};
      default: return m_scr[(o - 'h20) / 4];
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    int o;
    o = int'(a[7:0]);
    case (o)
      'h04: begin m_en = d[0]; m_rl = d[1]; m_mask = d[15:8]; end
      'h08: m_pend = m_pend & ~d[7:0];
      'h0C: m_pend = m_pend | d[7:0];
      'h10: begin m_load = d; m_cnt = d; end
      'h18: m_ch = d[2:0];
      default: if (o >= 'h20) m_scr[(o - 'h20) / 4] = d;
    endcase
  endtask

  function automatic bit is_fire(input int e, input int c0, input int l);
    return (e >= c0 + l) && ((e - c0 - l) % (l + 1) == 0);
  endfunction

  // One APB transfer starting at a falling edge; returns at the falling edge after commit.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err);
    int low;
    bus.paddr = a; bus.pwrite = wr; bus.pwdata = d; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    low = 0;
    #1;
    while (bus.pready !== 1'b1 && low < 40) begin
      low++;
      @(negedge clk);
      #1;
    end
    check_eq("wait_cycles", low, WAIT_CYC);
    rdata   = bus.prdata;
    err     = bus.pslverr;
    last_ce = cyc + 1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rdata, e_rd;
    logic        err, e_err;
    e_err = m_err(wr, a);
    e_rd  = (wr || e_err) ? 32'h0 : m_read(a);
    xfer(wr, a, d, rdata, err);
    check_eq({tag, "_err"}, err, e_err);
    check_eq({tag, "_rdata"}, rdata, e_rd);
    if (wr && !e_err) m_write(a, d);
  endtask

  task automatic wait_until(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_eq("wait_target", cyc, target);
  endtask

  logic [7:0]  offs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                             8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'hFC, 8'h21};
  logic [31:0] ra, rd, rhi, rdata;
  logic        rw, rerr;
  int          c, w, f, f2;

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_pready", bus.pready, 1);
    check_eq("rst_pslverr", bus.pslverr, 0);
    check_eq("rst_prdata", bus.prdata, 0);
    check_eq("rst_irq", irq, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ID, scratch with wait states, error responses
    do_op("id", 0, 32'h0000_0000, 0);
    do_op("scr0_wr", 1, 32'h20, 32'hDEAD_BEEF);
    do_op("scr0_rd", 0, 32'h20, 0);
    do_op("err_unmapped", 0, 32'h40, 0);
    do_op("err_wr_id", 1, 32'h00, 32'h1234);
    do_op("err_misalign_wr", 1, 32'h22, 32'h5555_AAAA);
    do_op("err_misalign_rd", 0, 32'h22, 0);
    do_op("err_wr_cnt", 1, 32'h14, 32'h77);
    do_op("id_after", 0, 32'h00, 0);
    do_op("scr0_after", 0, 32'h20, 0);
    do_op("cnt_after", 0, 32'h14, 0);

    // Randomized traffic with the timer kept disabled
    for (int i = 0; i < 60; i++) begin
      rhi = $urandom();
      rd  = $urandom();
      rw  = 1'($urandom_range(0, 1));
      ra  = {rhi[31:8], offs[$urandom_range(0, 15)]};
      if (ra[7:0] == 8'h04) rd[0] = 1'b0;
      @(negedge clk);
      check_eq("irq_model", irq, m_pend & m_mask);
      do_op("rand", rw, ra, rd);
    end

    // Timer on channel 0, load 5, auto reload
    do_op("t_load0", 1, 32'h10, 0);
    do_op("t_ch0", 1, 32'h18, 0);
    do_op("t_ctrl", 1, 32'h04, 32'h0000_0103);
    do_op("t_clr", 1, 32'h08, 32'hFF);
    @(negedge clk); @(negedge clk);
    check_eq("t_irq_clr", irq, 0);
    do_op("t_load5", 1, 32'h10, 5);
    c = last_ce;
    wait_until(c + 5);
    check_eq("t_irq_pre", irq[0], 0);
    @(negedge clk);
    check_eq("t_irq_fire", irq[0], 1);
    for (int k = 0; k < 3; k++) begin
      xfer(0, 32'h14, 0, rdata, rerr);
      check_eq("t_cnt", rdata, 32'(5 - ((last_ce - 1 - c) % 6)));
    end
    do_op("t_w1c", 1, 32'h08, 32'h01);
    w = last_ce;
    @(negedge clk);
    check_eq("t_irq_w1c", irq[0], is_fire(w, c, 5));
    f = c + 5 + 6 * ((w - c - 5) / 6 + 1);
    wait_until(f);
    check_eq("t_irq_prefire", irq[0], is_fire(w, c, 5));
    @(negedge clk);
    check_eq("t_irq_refire", irq[0], 1);

    // Set/clear race on channel 2
    do_op("r_load0", 1, 32'h10, 0);
    do_op("r_clr", 1, 32'h08, 32'hFF);
    do_op("r_ch2", 1, 32'h18, 2);
    do_op("r_ctrl", 1, 32'h04, 32'h0000_0403);
    do_op("r_swset", 1, 32'h0C, 32'h04);
    do_op("r_load5", 1, 32'h10, 5);
    c = last_ce;
    f = c + 11;
    wait_until(f - 5);
    do_op("r_w1c", 1, 32'h08, 32'h04);
    check_eq("r_land", last_ce, f);
    wait_until(f + 2);
    check_eq("r_irq_race", irq[2], 1);
    f2 = f + 6;
    wait_until(f2 - 3);
    do_op("r_w1c2", 1, 32'h08, 32'h04);
    check_eq("r_land2", last_ce, f2 + 2);
    @(negedge clk);
    check_eq("r_irq_clr", irq[2], 0);
    wait_until(f2 + 7);
    check_eq("r_irq_refire", irq[2], 1);

    // Reset in the middle of a wait-state write with the timer running
    do_op("m_pre", 1, 32'h24, 32'hCAFE_F00D);
    bus.paddr = 32'h24; bus.pwrite = 1'b1; bus.pwdata = 32'h1234_5678;
    bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    #1;
    check_eq("m_in_wait", bus.pready, 0);
    rst_n = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    check_eq("m_irq", irq, 0);
    check_eq("m_pready", bus.pready, 1);
    check_eq("m_pslverr", bus.pslverr, 0);
    check_eq("m_prdata", bus.prdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_op("m_scr1", 0, 32'h24, 0);
    do_op("m_ctrl", 0, 32'h04, 0);
    do_op("m_status", 0, 32'h08, 0);
    do_op("m_cnt", 0, 32'h14, 0);
    do_op("m_load", 0, 32'h10, 0);
    repeat (8) @(negedge clk);
    check_eq("m_irq_after", irq, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
